// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request at a time,
// buffers a single response against IF/ID stalls, and redirects on jumps and taken branches.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        enable,
  input  logic        jump_in,
  input  logic [25:0] Jump_Offset_in,
  input  logic [31:0] jump_pc_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_Counter_output,
  output logic [31:0] Instruction_memory_out,
  output logic        fetch_valid,
  output logic        flush_jump,
  output logic        flush_branch
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        discard_reg, discard_next;
  logic [31:0] hold_reg, hold_next;
  logic        fetch_valid_reg, fetch_valid_next;
  logic [31:0] pc_out_reg, pc_out_next;
  logic [31:0] instr_reg, instr_next;

  logic        redirect;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  assign redirect        = jump_in | branch_taken_in;
  assign jump_target     = (jump_pc_in & 32'hF000_0000) | {4'b0000, Jump_Offset_in, 2'b00};
  assign redirect_target = (branch_taken_in ? branch_target_in : jump_target) & 32'hFFFF_FFFC;
  assign pc_plus4        = pc_reg + 32'd4;

  assign flush_branch = branch_taken_in;
  // Branch is older than the jump in ID, so it suppresses the jump flush.
  assign flush_jump   = jump_in & ~branch_taken_in;

  assign imem_req               = (state_reg == S_REQ);
  assign imem_addr              = pc_reg;
  assign fetch_valid            = fetch_valid_reg;
  assign PC_Counter_output      = pc_out_reg;
  assign Instruction_memory_out = instr_reg;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    discard_next     = discard_reg;
    hold_next        = hold_reg;
    fetch_valid_next = fetch_valid_reg;
    pc_out_next      = pc_out_reg;
    instr_next       = instr_reg;

    if (redirect) begin
      pc_next          = redirect_target;
      fetch_valid_next = 1'b0;
      state_next       = S_REQ;
      // A request already accepted (or accepted now) will still answer; mark it stale.
      case (state_reg)
        S_REQ: begin
          if (imem_ready) begin
            state_next   = S_WAIT;
            discard_next = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_valid) begin
            discard_next = 1'b0;
          end else begin
            state_next   = S_WAIT;
            discard_next = 1'b1;
          end
        end
        default: state_next = S_REQ;
      endcase
    end else begin
      if (enable) fetch_valid_next = 1'b0;
      case (state_reg)
        S_REQ: begin
          if (imem_ready) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            if (discard_reg) begin
              discard_next = 1'b0;
              state_next   = S_REQ;
            end else if (!fetch_valid_reg || enable) begin
              instr_next       = imem_rdata;
              pc_out_next      = pc_plus4;
              fetch_valid_next = 1'b1;
              pc_next          = pc_plus4;
              state_next       = S_REQ;
            end else begin
              hold_next  = imem_rdata;
              state_next = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (enable) begin
            instr_next       = hold_reg;
            pc_out_next      = pc_plus4;
            fetch_valid_next = 1'b1;
            pc_next          = pc_plus4;
            state_next       = S_REQ;
          end
        end
        default: state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state_reg       <= S_REQ;
      pc_reg          <= {RESET_PC[31:2], 2'b00};
      discard_reg     <= 1'b0;
      hold_reg        <= 32'd0;
      fetch_valid_reg <= 1'b0;
      pc_out_reg      <= 32'd0;
      instr_reg       <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      discard_reg     <= discard_next;
      hold_reg        <= hold_next;
      fetch_valid_reg <= fetch_valid_next;
      pc_out_reg      <= pc_out_next;
      instr_reg       <= instr_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against
// a transaction-level model of the fetch stage and a latency-randomized memory.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, en, j, br, ready, valid;
  logic [25:0] off;
  logic [31:0] jpc, btgt, rdata;

  logic        req1, fv1, fj1, fb1;
  logic [31:0] addr1, pco1, ins1;
  logic        req2, fv2, fj2, fb2;
  logic [31:0] addr2, pco2, ins2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .reset_in(rst_n), .enable(en), .jump_in(j), .Jump_Offset_in(off),
    .jump_pc_in(jpc), .branch_taken_in(br), .branch_target_in(btgt),
    .imem_req(req1), .imem_addr(addr1), .imem_ready(ready), .imem_valid(valid),
    .imem_rdata(rdata), .PC_Counter_output(pco1), .Instruction_memory_out(ins1),
    .fetch_valid(fv1), .flush_jump(fj1), .flush_branch(fb1)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .reset_in(rst_n), .enable(en), .jump_in(j), .Jump_Offset_in(off),
    .jump_pc_in(jpc), .branch_taken_in(br), .branch_target_in(btgt),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(ready), .imem_valid(valid),
    .imem_rdata(rdata), .PC_Counter_output(pco2), .Instruction_memory_out(ins2),
    .fetch_valid(fv2), .flush_jump(fj2), .flush_branch(fb2)
  );

  // Reference model: next fetch PC, one outstanding response (possibly stale),
  // one pending buffered instruction, and the presented output pair.
  logic [31:0] m_pc, m_pdata, m_opc, m_oin;
  logic        m_busy, m_stale, m_pend, m_ov;

  // Memory responder state.
  logic        mem_auto = 1'b0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_lat = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_step();
    logic acc, resp, loaded;
    if (!rst_n) begin
      m_pc = 32'd0; m_busy = 0; m_stale = 0; m_pend = 0; m_pdata = 0;
      m_ov = 0; m_opc = 0; m_oin = 0;
      return;
    end
    acc  = !m_busy && !m_pend && ready;
    resp = m_busy && valid;
    if (j || br) begin
      m_pc = (br ? btgt : {jpc[31:28], off, 2'b00}) & 32'hFFFF_FFFC;
      m_ov = 0; m_pend = 0;
      if (acc) begin m_busy = 1; m_stale = 1; end
      else if (resp) begin m_busy = 0; m_stale = 0; end
      else if (m_busy) m_stale = 1;
    end else begin
      loaded = 0;
      if (acc) m_busy = 1;
      else if (resp) begin
        m_busy = 0;
        if (m_stale) m_stale = 0;
        else if (!m_ov || en) begin
          m_ov = 1; m_oin = rdata; m_opc = m_pc + 4; m_pc = m_pc + 4; loaded = 1;
        end else begin
          m_pend = 1; m_pdata = rdata;
        end
      end else if (m_pend && en) begin
        m_pend = 0; m_ov = 1; m_oin = m_pdata; m_opc = m_pc + 4; m_pc = m_pc + 4; loaded = 1;
      end
      if (en && !loaded) m_ov = 0;
    end
  endtask

  // Advance one clock: update the model, then the memory responder, sample #1 after the edge.
  task automatic tick();
    logic        req_now;
    logic [31:0] addr_now;
    model_step();
    req_now  = req1;
    addr_now = addr1;
    @(posedge clk);
    if (mem_auto) begin
      if (!rst_n) mem_pend = 0;
      else begin
        if (mem_pend && valid) mem_pend = 0;
        else if (mem_pend && mem_lat > 0) mem_lat--;
        if (req_now && ready && !mem_pend) begin
          mem_pend = 1; mem_addr = addr_now; mem_lat = $urandom_range(0, 2);
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; j = 0; br = 0; ready = 0; valid = 0;
    off = 0; jpc = 0; btgt = 0; rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    total++; if (fv1 !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", fv1); end
    total++; if (pco1 !== 32'd0) begin bad++; $display("FAIL reset_pco got=%h want=0", pco1); end
    total++; if (ins1 !== 32'd0) begin bad++; $display("FAIL reset_ins got=%h want=0", ins1); end
    rst_n = 1;
    #1;
    total++; if (req1 !== 1'b1 || addr1 !== 32'd0) begin bad++;
      $display("FAIL reset_req got=%b/%h want=1/00000000", req1, addr1); end
    $display("test_reset done");
  endtask

  task automatic test_basic_fetch();
    ready = 1; en = 1; #1;
    total++; if (req1 !== 1'b1 || addr1 !== 32'd0) begin bad++;
      $display("FAIL basic_req got=%b/%h want=1/00000000", req1, addr1); end
    tick();
    ready = 0; valid = 1; rdata = 32'h226A0004;
    tick();
    valid = 0;
    total++; if (fv1 !== 1'b1 || ins1 !== 32'h226A0004 || pco1 !== 32'd4) begin bad++;
      $display("FAIL basic_out got=%b/%h/%h want=1/226a0004/00000004", fv1, ins1, pco1); end
    #1;
    total++; if (req1 !== 1'b1 || addr1 !== 32'd4) begin bad++;
      $display("FAIL basic_next got=%b/%h want=1/00000004", req1, addr1); end
    $display("test_basic_fetch done");
  endtask

  task automatic test_hold();
    en = 0; ready = 1;
    tick();
    ready = 0; valid = 1; rdata = 32'h02328020;
    tick();
    valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++; if (fv1 !== 1'b1 || ins1 !== 32'h226A0004 || pco1 !== 32'd4 || req1 !== 1'b0) begin bad++;
        $display("FAIL hold_stall%0d got=%b/%h/%h/%b want=1/226a0004/00000004/0", i, fv1, ins1, pco1, req1); end
      if (i < 2) tick();
    end
    en = 1;
    tick();
    total++; if (fv1 !== 1'b1 || ins1 !== 32'h02328020 || pco1 !== 32'd8) begin bad++;
      $display("FAIL hold_release got=%b/%h/%h want=1/02328020/00000008", fv1, ins1, pco1); end
    total++; if (req1 !== 1'b1 || addr1 !== 32'd8) begin bad++;
      $display("FAIL hold_next got=%b/%h want=1/00000008", req1, addr1); end
    $display("test_hold done");
  endtask

  task automatic test_jump();
    ready = 1; en = 1;
    tick();
    ready = 0; j = 1; jpc = 32'h00000008; off = 26'h0000101; #1;
    total++; if (fj1 !== 1'b1 || fb1 !== 1'b0) begin bad++;
      $display("FAIL jump_flush got=%b/%b want=1/0", fj1, fb1); end
    tick();
    j = 0; valid = 1; rdata = 32'hDEADBEEF;
    tick();
    valid = 0; #1;
    total++; if (fv1 !== 1'b0) begin bad++; $display("FAIL jump_discard got=%b want=0", fv1); end
    total++; if (req1 !== 1'b1 || addr1 !== 32'h00000404) begin bad++;
      $display("FAIL jump_target got=%b/%h want=1/00000404", req1, addr1); end
    $display("test_jump done");
  endtask

  task automatic test_branch_over_jump();
    j = 1; br = 1; btgt = 32'h00000043; jpc = 32'h10000000; off = 26'h3FFFFFF; #1;
    total++; if (fb1 !== 1'b1 || fj1 !== 1'b0) begin bad++;
      $display("FAIL both_flush got=%b/%b want=1/0", fb1, fj1); end
    tick();
    j = 0; br = 0; #1;
    total++; if (req1 !== 1'b1 || addr1 !== 32'h00000040) begin bad++;
      $display("FAIL both_target got=%b/%h want=1/00000040", req1, addr1); end
    $display("test_branch_over_jump done");
  endtask

  task automatic test_wrap();
    do_reset();
    total++; if (req2 !== 1'b1 || addr2 !== 32'hFFFFFFFC) begin bad++;
      $display("FAIL wrap_first got=%b/%h want=1/fffffffc", req2, addr2); end
    ready = 1; en = 1;
    tick();
    ready = 0; valid = 1; rdata = 32'h00000011;
    tick();
    valid = 0; #1;
    total++; if (fv2 !== 1'b1 || pco2 !== 32'd0 || ins2 !== 32'h11) begin bad++;
      $display("FAIL wrap_out got=%b/%h/%h want=1/00000000/00000011", fv2, pco2, ins2); end
    total++; if (req2 !== 1'b1 || addr2 !== 32'd0) begin bad++;
      $display("FAIL wrap_next got=%b/%h want=1/00000000", req2, addr2); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_inflight();
    do_reset();
    ready = 1; en = 1;
    tick();
    ready = 0; rst_n = 0; valid = 1; rdata = 32'hCAFEF00D;
    tick(); tick();
    rst_n = 1;
    tick();
    valid = 0; #1;
    total++; if (fv1 !== 1'b0) begin bad++; $display("FAIL rst_inflight_fv got=%b want=0", fv1); end
    total++; if (req1 !== 1'b1 || addr1 !== 32'd0) begin bad++;
      $display("FAIL rst_inflight_req got=%b/%h want=1/00000000", req1, addr1); end
    $display("test_reset_inflight done");
  endtask

  task automatic test_random();
    int r;
    int errs_before;
    errs_before = bad;
    mem_auto = 1; mem_pend = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      en = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 39);
      j = (r == 0) || (r == 1);
      br = (r == 1) || (r == 2);
      off = 26'($urandom); jpc = $urandom; btgt = $urandom;
      ready = $urandom_range(0, 1) == 1;
      if (mem_pend && mem_lat == 0) begin valid = 1; rdata = mem_data(mem_addr); end
      else if (!mem_pend && !m_busy && $urandom_range(0, 7) == 0) begin valid = 1; rdata = $urandom; end
      else begin valid = 0; rdata = $urandom; end
      #1;
      total++; if (req1 !== (!m_busy && !m_pend)) begin bad++;
        $display("FAIL rnd_req cyc=%0d got=%b want=%b", cyc, req1, !m_busy && !m_pend); end
      if (!m_busy && !m_pend) begin
        total++; if (addr1 !== m_pc) begin bad++;
          $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, addr1, m_pc); end
      end
      total++; if (fb1 !== br || fj1 !== (j & ~br)) begin bad++;
        $display("FAIL rnd_flush cyc=%0d got=%b/%b want=%b/%b", cyc, fb1, fj1, br, j & ~br); end
      tick();
      total++; if (fv1 !== m_ov) begin bad++;
        $display("FAIL rnd_fv cyc=%0d got=%b want=%b", cyc, fv1, m_ov); end
      if (m_ov) begin
        total++; if (pco1 !== m_opc || ins1 !== m_oin) begin bad++;
          $display("FAIL rnd_pair cyc=%0d got=%h/%h want=%h/%h", cyc, pco1, ins1, m_opc, m_oin); end
      end
    end
    mem_auto = 0;
    $display("test_random done errors=%0d", bad - errs_before);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_hold();
    test_jump();
    test_branch_over_jump();
    test_wrap();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the PC+4 / instruction pair consumed by the IF/ID pipeline register, and generates that register's flush_jump / flush_branch controls. It owns the PC register and drives a single-outstanding-request instruction-memory handshake. It absorbs memory latency and IF/ID stalls (enable low) with a one-entry hold buffer. It redirects on jumps (decoded in ID) and taken branches (resolved in EX), discarding stale fetches.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset (low 2 bits forced 0)

Ports:
clk  in  1  clock, rising edge
reset_in  in  1  synchronous, active-low reset
enable  in  1  IF/ID advance: 1 = IF/ID latches this edge, 0 = stall
jump_in  in  1  ID stage decoded j-type
Jump_Offset_in  in  26  instr[25:0] from IF/ID
jump_pc_in  in  32  IF/ID PC_Counter_out (PC+4 of the jump)
branch_taken_in  in  1  EX stage taken branch
branch_target_in  in  32  branch target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_ready  in  1  request accepted this cycle
imem_valid  in  1  response data valid
imem_rdata  in  32  response instruction
PC_Counter_output  out  32  PC+4 of presented instruction
Instruction_memory_out  out  32  presented instruction
fetch_valid  out  1  output pair is valid
flush_jump  out  1  clear IF/ID (jump)
flush_branch  out  1  clear IF/ID (branch)

Behaviour:
- Reset (reset_in=0 at edge): pc_q=RESET_PC, state=S_REQ, fetch_valid=0, PC_Counter_output=0, Instruction_memory_out=0, hold empty, discard=0. imem_req=1 in the first cycle after release. Any imem_valid arriving in S_REQ is ignored.
- States: S_REQ, S_WAIT, S_HOLD.
- S_REQ: imem_req=1, imem_addr=pc_q. imem_ready=1 -> S_WAIT.
- S_WAIT: imem_req=0. On imem_valid:
  - discard=1: drop the data, clear discard, -> S_REQ.
  - Output slot free (fetch_valid=0 or enable=1): load Instruction_memory_out=imem_rdata, PC_Counter_output=pc_q+4, fetch_valid=1, pc_q<=pc_q+4, -> S_REQ.
  - Otherwise: store data in the hold buffer, -> S_HOLD.
- S_HOLD: when enable=1, move the hold buffer to the output registers, pc_q<=pc_q+4, -> S_REQ.
- If the output is consumed (enable=1) and no new data is loaded, fetch_valid<=0.
- Latency: minimum 2 cycles from request to fetch_valid (ready in the request cycle, valid the next cycle).
- Redirect (combinational):
  - flush_branch=branch_taken_in.
  - flush_jump=jump_in & ~branch_taken_in. The branch wins when both are asserted, since it is the older instruction.
  - Target: branch_target_in, or {jump_pc_in[31:28], Jump_Offset_in, 2'b00}. The low 2 bits are always forced 0.
- On a redirect edge:
  - pc_q<=target, fetch_valid<=0, hold emptied.
  - State -> S_REQ, except S_WAIT without same-cycle imem_valid -> stay in S_WAIT with discard=1.
  - S_REQ with imem_ready=1 the same cycle -> S_WAIT with discard=1.
  - Redirect overrides enable and any same-cycle data load.
- PC arithmetic: 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- Redirect during S_WAIT with discard already set: update pc_q only; discard stays 1 (still one response outstanding).
- Reset has priority over all events, including an in-flight memory response.

Test Plan:
- Reset, then imem_ready=1 and valid one cycle later with rdata=32'h22 6A 00 04 (0x226A0004), enable=1 -> imem_addr=0; fetch_valid=1, Instruction_memory_out=0x226A0004, PC_Counter_output=4; next imem_addr=4.
- Response 0x02328020 arrives with fetch_valid=1 and enable=0 for 3 cycles -> state S_HOLD, output unchanged; on enable=1 the new pair (PC+4=8) appears, then the request for addr 8.
- jump_in=1, jump_pc_in=0x00000008, Jump_Offset_in=26'h0000101 while in S_WAIT -> flush_jump=1 that cycle; the in-flight response is discarded; next imem_addr=0x00000404.
- jump_in=1 and branch_taken_in=1 (target 0x40) in the same cycle -> flush_branch=1, flush_jump=0, next imem_addr=0x40.
- RESET_PC=32'hFFFFFFFC, one fetch completes -> PC_Counter_output=0, next imem_addr=0.
- reset_in=0 asserted in S_WAIT, imem_valid arriving during reset and on the first cycle after release -> response ignored, fetch_valid=0, imem_req=1 with imem_addr=RESET_PC.
